// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: parametrised MEM->WB pipeline register.
// Carries load data, ALU result, destination and writeback control through
// DEPTH stages with stall, flush, per-stage valid and a youngest-first
// forwarding lookup across all in-flight stages.
// Optional feature macro: MEM_WB_STATS_EN (adds wr_count_o / flush_count_o).
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] RDData_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] RDData_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
`ifdef MEM_WB_STATS_EN
  ,
  output logic [31:0]       wr_count_o,
  output logic [31:0]       flush_count_o
`endif
);

  // Reject unsupported pipeline depths while elaborating.
  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("mem_wb_pipe: DEPTH must be in 1..4");
  end

  localparam int unsigned LAST = DEPTH - 1;

  // Stage 0 is the youngest entry, stage LAST drives the outputs.
  logic [DEPTH-1:0]  st_valid;
  logic [DEPTH-1:0]  st_rw;
  logic [DEPTH-1:0]  st_m2r;
  logic [ADDR_W-1:0] st_addr [DEPTH];
  logic [DATA_W-1:0] st_rd   [DEPTH];
  logic [DATA_W-1:0] st_alu  [DEPTH];
  logic [DATA_W-1:0] st_wb   [DEPTH];

  // Stage registers: reset clears all, flush kills control, otherwise shift unless stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_valid <= '0;
      st_rw    <= '0;
      st_m2r   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        st_addr[k] <= '0;
        st_rd[k]   <= '0;
        st_alu[k]  <= '0;
      end
    end else if (flush_i) begin
      // Data/address fields are left untouched; valid gating makes them inert.
      st_valid <= '0;
      st_rw    <= '0;
      st_m2r   <= '0;
    end else if (!stall_i) begin
      st_valid[0] <= valid_i;
      st_rw[0]    <= RegWrite_i & valid_i;
      st_m2r[0]   <= MemToReg_i;
      st_addr[0]  <= RDaddr_i;
      st_rd[0]    <= RDData_i;
      st_alu[0]   <= ALUResult_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_rw[k]    <= st_rw[k-1];
        st_m2r[k]   <= st_m2r[k-1];
        st_addr[k]  <= st_addr[k-1];
        st_rd[k]    <= st_rd[k-1];
        st_alu[k]   <= st_alu[k-1];
      end
    end
  end

  // Per-stage writeback value, shared by the output mux and forwarding.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      st_wb[k] = st_m2r[k] ? st_rd[k] : st_alu[k];
    end
  end

  assign valid_o     = st_valid[LAST];
  assign RDData_o    = st_rd[LAST];
  assign ALUResult_o = st_alu[LAST];
  assign RDaddr_o    = st_addr[LAST];
  assign RegWrite_o  = st_rw[LAST] & st_valid[LAST];
  assign MemToReg_o  = st_m2r[LAST];
  assign wb_data_o   = st_wb[LAST];

  // Forwarding lookup: first match scanning from stage 0 is the youngest writer.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!fwd_hit_o && st_valid[k] && st_rw[k] &&
          (st_addr[k] == fwd_addr_i) && (st_addr[k] != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = st_wb[k];
      end
    end
  end

`ifdef MEM_WB_STATS_EN
  // Saturating counters of retired writes and flushes that killed live entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_count_o    <= '0;
      flush_count_o <= '0;
    end else begin
      if (RegWrite_o && !stall_i && (wr_count_o != '1)) begin
        wr_count_o <= wr_count_o + 32'd1;
      end
      if (flush_i && (|st_valid) && (flush_count_o != '1)) begin
        flush_count_o <= flush_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: drives DEPTH=1 and DEPTH=3 instances with shared stimulus
// and checks both against a behavioural in-flight entry model every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_mem_wb_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, valid_i, RegWrite_i, MemToReg_i;
  logic [31:0] RDData_i, ALUResult_i;
  logic [4:0]  RDaddr_i, fwd_addr_i;

  logic        o_valid [2];
  logic [31:0] o_rd    [2];
  logic [31:0] o_alu   [2];
  logic [4:0]  o_addr  [2];
  logic        o_rw    [2];
  logic        o_m2r   [2];
  logic [31:0] o_wb    [2];
  logic        o_fhit  [2];
  logic [31:0] o_fdat  [2];
`ifdef MEM_WB_STATS_EN
  logic [31:0] o_wrc   [2];
  logic [31:0] o_flc   [2];
`endif

  int vectors    = 0;
  int miscompares = 0;
  bit cmp_en     = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .DEPTH(1)) u_d1 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .RDData_i(RDData_i), .ALUResult_i(ALUResult_i),
    .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .valid_o(o_valid[0]), .RDData_o(o_rd[0]), .ALUResult_o(o_alu[0]),
    .RDaddr_o(o_addr[0]), .RegWrite_o(o_rw[0]), .MemToReg_o(o_m2r[0]),
    .wb_data_o(o_wb[0]), .fwd_addr_i(fwd_addr_i), .fwd_hit_o(o_fhit[0]),
    .fwd_data_o(o_fdat[0])
`ifdef MEM_WB_STATS_EN
    , .wr_count_o(o_wrc[0]), .flush_count_o(o_flc[0])
`endif
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .DEPTH(3)) u_d3 (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .RDData_i(RDData_i), .ALUResult_i(ALUResult_i),
    .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .valid_o(o_valid[1]), .RDData_o(o_rd[1]), .ALUResult_o(o_alu[1]),
    .RDaddr_o(o_addr[1]), .RegWrite_o(o_rw[1]), .MemToReg_o(o_m2r[1]),
    .wb_data_o(o_wb[1]), .fwd_addr_i(fwd_addr_i), .fwd_hit_o(o_fhit[1]),
    .fwd_data_o(o_fdat[1])
`ifdef MEM_WB_STATS_EN
    , .wr_count_o(o_wrc[1]), .flush_count_o(o_flc[1])
`endif
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [4:0]  a;
    logic [31:0] rd;
    logic [31:0] alu;
  } ent_t;

  ent_t        pipe [2][4];   // index 0 = youngest in-flight entry
  logic [31:0] m_wrc [2];
  logic [31:0] m_flc [2];

  function automatic int dep(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Model evolves once per rising edge, and clears at once on reset.
  always @(posedge clk_i or posedge rst_i) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_i) begin
        for (int k = 0; k < 4; k++) pipe[d][k] = '0;
        m_wrc[d] = 0;
        m_flc[d] = 0;
      end else begin
        bit any_v;
        ent_t nw;
        any_v = 1'b0;
        for (int k = 0; k < dep(d); k++) any_v |= pipe[d][k].v;
        if (pipe[d][dep(d)-1].v && pipe[d][dep(d)-1].rw && !stall_i && m_wrc[d] != 32'hFFFF_FFFF)
          m_wrc[d] = m_wrc[d] + 1;
        if (flush_i && any_v && m_flc[d] != 32'hFFFF_FFFF)
          m_flc[d] = m_flc[d] + 1;
        if (flush_i) begin
          for (int k = 0; k < 4; k++) begin
            pipe[d][k].v = 1'b0; pipe[d][k].rw = 1'b0; pipe[d][k].m2r = 1'b0;
          end
        end else if (!stall_i) begin
          nw = '{v: valid_i, rw: RegWrite_i & valid_i, m2r: MemToReg_i,
                 a: RDaddr_i, rd: RDData_i, alu: ALUResult_i};
          for (int k = 3; k > 0; k--) pipe[d][k] = pipe[d][k-1];
          pipe[d][0] = nw;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        ent_t e;
        logic        fh;
        logic [31:0] fdat;
        e = pipe[d][dep(d)-1];
        chk($sformatf("d%0d valid_o", d), 64'(o_valid[d]), 64'(e.v));
        chk($sformatf("d%0d RegWrite_o", d), 64'(o_rw[d]), 64'(e.v & e.rw));
        chk($sformatf("d%0d MemToReg_o", d), 64'(o_m2r[d]), 64'(e.m2r));
        if (e.v) begin
          chk($sformatf("d%0d RDaddr_o", d), 64'(o_addr[d]), 64'(e.a));
          chk($sformatf("d%0d RDData_o", d), 64'(o_rd[d]), 64'(e.rd));
          chk($sformatf("d%0d ALUResult_o", d), 64'(o_alu[d]), 64'(e.alu));
          chk($sformatf("d%0d wb_data_o", d), 64'(o_wb[d]), 64'(e.m2r ? e.rd : e.alu));
        end
        fh = 1'b0;
        fdat = '0;
        for (int k = 0; k < dep(d); k++) begin
          if (!fh && pipe[d][k].v && pipe[d][k].rw && pipe[d][k].a == fwd_addr_i && fwd_addr_i != 0) begin
            fh = 1'b1;
            fdat = pipe[d][k].m2r ? pipe[d][k].rd : pipe[d][k].alu;
          end
        end
        chk($sformatf("d%0d fwd_hit_o", d), 64'(o_fhit[d]), 64'(fh));
        chk($sformatf("d%0d fwd_data_o", d), 64'(o_fdat[d]), 64'(fdat));
`ifdef MEM_WB_STATS_EN
        chk($sformatf("d%0d wr_count_o", d), 64'(o_wrc[d]), 64'(m_wrc[d]));
        chk($sformatf("d%0d flush_count_o", d), 64'(o_flc[d]), 64'(m_flc[d]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle();
    valid_i = 0; RegWrite_i = 0; MemToReg_i = 0; RDaddr_i = 0;
    RDData_i = 0; ALUResult_i = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] rd,
                      input logic [31:0] alu, input logic m2r);
    valid_i = 1; RegWrite_i = 1; MemToReg_i = m2r; RDaddr_i = a;
    RDData_i = rd; ALUResult_i = alu;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, " valid_o"}, 64'(o_valid[d]), 64'd0);
    chk({tag, " RegWrite_o"}, 64'(o_rw[d]), 64'd0);
    chk({tag, " MemToReg_o"}, 64'(o_m2r[d]), 64'd0);
    chk({tag, " RDaddr_o"}, 64'(o_addr[d]), 64'd0);
    chk({tag, " RDData_o"}, 64'(o_rd[d]), 64'd0);
    chk({tag, " ALUResult_o"}, 64'(o_alu[d]), 64'd0);
    chk({tag, " wb_data_o"}, 64'(o_wb[d]), 64'd0);
    chk({tag, " fwd_hit_o"}, 64'(o_fhit[d]), 64'd0);
    chk({tag, " fwd_data_o"}, 64'(o_fdat[d]), 64'd0);
  endtask

  initial begin
    rst_i = 1; idle(); fwd_addr_i = 0;
    cyc(); cyc();
    chk_zero(0, "reset d1");
    chk_zero(1, "reset d3");
    rst_i = 0;
    cmp_en = 1;

    // Single entry: DEPTH=1 shows it after one edge, DEPTH=3 after three.
    push(5'd7, 32'h5555, 32'h1234, 1'b0);
    cyc(); idle();
    chk("t1 d1 RegWrite_o", 64'(o_rw[0]), 64'd1);
    chk("t1 d1 RDaddr_o", 64'(o_addr[0]), 64'd7);
    chk("t1 d1 wb_data_o", 64'(o_wb[0]), 64'h1234);
    chk("t1 d3 valid_o early", 64'(o_valid[1]), 64'd0);
    cyc(); cyc();
    chk("t1 d3 RegWrite_o", 64'(o_rw[1]), 64'd1);
    chk("t1 d3 RDaddr_o", 64'(o_addr[1]), 64'd7);
    chk("t1 d3 wb_data_o", 64'(o_wb[1]), 64'h1234);

    // Back-to-back entries emerge in order on edges 3, 4, 5.
    push(5'd1, 32'h0, 32'h11, 1'b0); cyc();
    push(5'd2, 32'hDEAD, 32'h22, 1'b1); cyc();
    push(5'd3, 32'h0, 32'h33, 1'b0); cyc();
    idle();
    chk("t2 addr edge3", 64'(o_addr[1]), 64'd1);
    chk("t2 wb edge3", 64'(o_wb[1]), 64'h11);
    cyc();
    chk("t2 addr edge4", 64'(o_addr[1]), 64'd2);
    chk("t2 wb edge4", 64'(o_wb[1]), 64'hDEAD);
    cyc();
    chk("t2 addr edge5", 64'(o_addr[1]), 64'd3);
    chk("t2 wb edge5", 64'(o_wb[1]), 64'h33);
    cyc();

    // Stall freezes the pipe and forwarding; the entry emerges two edges late.
    push(5'd9, 32'h0, 32'h99, 1'b0); cyc();
    idle(); stall_i = 1; fwd_addr_i = 5'd9;
    cyc(); cyc();
    chk("t3 d3 valid_o stalled", 64'(o_valid[1]), 64'd0);
    chk("t3 d3 fwd_hit_o", 64'(o_fhit[1]), 64'd1);
    chk("t3 d3 fwd_data_o", 64'(o_fdat[1]), 64'h99);
    chk("t3 d1 held addr", 64'(o_addr[0]), 64'd9);
    stall_i = 0;
    cyc();
    chk("t3 d3 valid_o mid", 64'(o_valid[1]), 64'd0);
    cyc();
    chk("t3 d3 valid_o late", 64'(o_valid[1]), 64'd1);
    chk("t3 d3 RDaddr_o late", 64'(o_addr[1]), 64'd9);

    // Flush beats stall and the incoming entry.
    push(5'd4, 32'h0, 32'h44, 1'b0); cyc();
    push(5'd6, 32'h0, 32'h66, 1'b0); stall_i = 1; flush_i = 1;
    cyc(); idle();
    fwd_addr_i = 5'd6; #1;
    chk("t4 d1 valid_o", 64'(o_valid[0]), 64'd0);
    chk("t4 d1 RegWrite_o", 64'(o_rw[0]), 64'd0);
    chk("t4 d3 valid_o", 64'(o_valid[1]), 64'd0);
    chk("t4 d1 fwd_hit_o r6", 64'(o_fhit[0]), 64'd0);
    fwd_addr_i = 5'd4; #1;
    chk("t4 d3 fwd_hit_o r4", 64'(o_fhit[1]), 64'd0);
    cyc();

    // Youngest writer wins forwarding; r0 never hits.
    push(5'd5, 32'h0, 32'hAA, 1'b0); cyc();
    push(5'd5, 32'h0, 32'hBB, 1'b0); cyc();
    idle(); fwd_addr_i = 5'd5; #1;
    chk("t5 d3 fwd_hit_o", 64'(o_fhit[1]), 64'd1);
    chk("t5 d3 fwd_data_o", 64'(o_fdat[1]), 64'hBB);
    chk("t5 d1 fwd_data_o", 64'(o_fdat[0]), 64'hBB);
    fwd_addr_i = 5'd0; #1;
    chk("t5 d3 fwd_hit_o r0", 64'(o_fhit[1]), 64'd0);
    chk("t5 d3 fwd_data_o r0", 64'(o_fdat[1]), 64'd0);
    fwd_addr_i = 5'd5;
    cyc();
    chk("t5 d3 fwd_data_o older", 64'(o_fdat[1]), 64'hBB);

    // Asynchronous reset between edges with a full pipe.
    push(5'd10, 32'h1, 32'hA0, 1'b1); cyc();
    push(5'd11, 32'h2, 32'hB0, 1'b0); cyc();
    push(5'd12, 32'h3, 32'hC0, 1'b1); cyc();
    rst_i = 1; #1;
    chk_zero(0, "t6 d1 async rst");
    chk_zero(1, "t6 d3 async rst");
    idle(); fwd_addr_i = 0;
    cyc();
    rst_i = 0;

    // Three retired writes and one flush of live entries.
    push(5'd1, 32'h0, 32'h1, 1'b0); cyc();
    push(5'd2, 32'h0, 32'h2, 1'b0); cyc();
    push(5'd3, 32'h0, 32'h3, 1'b0); cyc();
    idle(); cyc();
    valid_i = 1; cyc();
    idle(); flush_i = 1; cyc();
    idle();
`ifdef MEM_WB_STATS_EN
    chk("t6 d1 wr_count_o", 64'(o_wrc[0]), 64'd3);
    chk("t6 d1 flush_count_o", 64'(o_flc[0]), 64'd1);
`endif
    chk("t6 d1 valid_o after flush", 64'(o_valid[0]), 64'd0);

    // Randomized traffic with occasional stall, flush and reset.
    for (int n = 0; n < 3000; n++) begin
      valid_i     = ($urandom_range(0, 3) != 0);
      RegWrite_i  = 1'($urandom_range(0, 1));
      MemToReg_i  = 1'($urandom_range(0, 1));
      RDaddr_i    = 5'($urandom_range(0, 7));
      RDData_i    = $urandom;
      ALUResult_i = $urandom;
      stall_i     = ($urandom_range(0, 9) == 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      fwd_addr_i  = 5'($urandom_range(0, 7));
      rst_i       = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst_i = 0; idle();
    cyc(); cyc();
    cmp_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM->WB pipeline register, the successor to the fixed single-stage 32-bit MEM/WB latch. It carries load data, ALU result, destination address and writeback control through DEPTH register stages, with stall, flush, per-stage valid tracking and a writeback-data mux. It also offers a forwarding lookup across all in-flight stages. It sits between the data-memory stage and the register file write port.

Parameters:
DATA_W, 32, width of RDData and ALUResult paths
ADDR_W, 5, register-address width
DEPTH, 1, number of register stages (1..4); DEPTH=1 matches the legacy single-stage timing

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
stall_i  in  1  hold all stages
flush_i  in  1  invalidate all stages
valid_i  in  1  incoming entry is a real instruction
RDData_i  in  DATA_W  memory read data
ALUResult_i  in  DATA_W  ALU result
RDaddr_i  in  ADDR_W  destination register
RegWrite_i  in  1  writeback enable
MemToReg_i  in  1  select memory data for writeback
valid_o  out  1  last-stage valid
RDData_o  out  DATA_W  last-stage memory data
ALUResult_o  out  DATA_W  last-stage ALU result
RDaddr_o  out  ADDR_W  last-stage destination
RegWrite_o  out  1  last-stage write enable, gated by valid
MemToReg_o  out  1  last-stage select
wb_data_o  out  DATA_W  MemToReg_o ? RDData_o : ALUResult_o
fwd_addr_i  in  ADDR_W  forwarding query address
fwd_hit_o  out  1  some valid in-flight stage writes fwd_addr_i
fwd_data_o  out  DATA_W  writeback data of the youngest matching stage

Behaviour:
- Reset (async, immediate): every stage's valid, RegWrite, MemToReg, RDaddr, RDData and ALUResult go to 0. Therefore all outputs are 0, including wb_data_o, fwd_hit_o and fwd_data_o.
- Normal cycle (no stall, no flush): stage0 <= inputs; stage k <= stage k-1. An input appears on the outputs exactly DEPTH rising edges after it is presented.
- Stored RegWrite = RegWrite_i & valid_i. An invalid entry never asserts RegWrite_o.
- stall_i=1, flush_i=0: all stages hold, including valid. Inputs are ignored.
- flush_i=1: on the edge, all stage valid, RegWrite and MemToReg bits clear; data and address fields are don't-care. Flush takes priority over stall and over the incoming entry, so the input that cycle is dropped.
- Outputs are registered from the last stage; only wb_data_o and the fwd_* outputs are combinational.
- Forwarding:
  - A stage matches when valid & RegWrite & (RDaddr == fwd_addr_i) & (RDaddr != 0).
  - Priority is youngest first (stage0, then stage1, ...).
  - fwd_data_o is the matching stage's MemToReg ? RDData : ALUResult, and 0 when there is no hit.
  - fwd_addr_i = 0 never hits.
- Reset asserted mid-stream clears everything immediately. The first entry after reset deassertion is captured on the next rising edge.
- DEPTH outside 1..4 is a configuration error and must trigger an elaboration-time check.

Optional Feature:
- Macro: MEM_WB_STATS_EN.
- When defined, two extra output ports are added: wr_count_o (32) and flush_count_o (32).
  - wr_count_o increments on each edge where the last stage has RegWrite_o=1 and stall_i=0.
  - flush_count_o increments on each edge where flush_i=1 and at least one stage is valid.
  - Both counters saturate at 0xFFFFFFFF and reset to 0 on rst_i.
- When undefined, the ports and logic are absent and the interface is exactly as listed above.

Test Plan:
1. DEPTH=1, reset, then valid_i=1 RegWrite_i=1 MemToReg_i=0 ALUResult_i=0x1234 RDaddr_i=7 -> one edge later RegWrite_o=1, RDaddr_o=7, wb_data_o=0x1234.
2. DEPTH=3, three back-to-back entries with RDaddr 1,2,3 -> they emerge in order on edges 3,4,5; MemToReg_i=1 with RDData_i=0xDEAD yields wb_data_o=0xDEAD.
3. DEPTH=2, stall_i held 2 cycles with an entry in stage0 -> outputs and fwd_* frozen; the entry emerges 2 cycles late.
4. DEPTH=2, stall_i=1 and flush_i=1 together -> next edge valid_o=0, RegWrite_o=0, fwd_hit_o=0; the incoming entry is lost.
5. DEPTH=3, stages hold writes to r5 (older, 0xAA) and r5 (younger, 0xBB), fwd_addr_i=5 -> fwd_hit_o=1, fwd_data_o=0xBB; fwd_addr_i=0 -> fwd_hit_o=0.
6. Assert rst_i between clock edges with a full pipe -> all outputs 0 immediately. With MEM_WB_STATS_EN: 3 retired writes plus 1 flush -> wr_count_o=3, flush_count_o=1.
